// File: rtl/digit_swap_sched.sv
// digit_swap_sched
// Chooses which mod-6 counter value drives each seven-segment digit. Every
// PERIOD ticks the upper digit is blanked for BLANK_TICKS ticks, and then the
// two digits swap. A synchronised hold button freezes the digits and the
// schedule.
//
// Parameters:
//   PERIOD      ticks spent in RUN between swaps (2..2^CW)
//   BLANK_TICKS ticks the upper digit is dark before each swap (1..2^CW)
//   CW          width of the period and blank counters
// Ports:
//   clk_slow    slow divided clock; all state changes on its rising edge
//   rst         synchronous reset, active-low
//   hold_n      raw hold pushbutton, active-low, asynchronous to clk_slow
//   cnt_a/b     counter values (0..5; values 6 and 7 pass through unchanged)
//   digit0/1    registered values for the lower and upper decoders
//   blank1      registered; 1 = drive the upper display dark
//   swapped     0: digit0=cnt_a, digit1=cnt_b; 1: the reverse
//   swap_pulse  one-cycle pulse in the cycle swapped toggles
//   holding     1 while in HOLD
//
// state | meaning
// RUN   | digits follow the counters, period counter advancing
// BLANK | upper digit dark, blank counter advancing toward the swap
// HOLD  | digits, swap state and period counter frozen
module digit_swap_sched #(
  parameter int PERIOD      = 30,
  parameter int BLANK_TICKS = 2,
  parameter int CW          = 5
) (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic       hold_n,
  input  logic [2:0] cnt_a,
  input  logic [2:0] cnt_b,
  output logic [2:0] digit0,
  output logic [2:0] digit1,
  output logic       blank1,
  output logic       swapped,
  output logic       swap_pulse,
  output logic       holding
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_BLANK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] P_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_TICKS - 1);

  state_t        state;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] bcnt;
  logic          pend;
  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          press;

  // Falling edge of the synchronised button; one cycle per press.
  assign press = sync_prev & ~sync2;

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state      <= S_RUN;
      pcnt       <= '0;
      bcnt       <= '0;
      pend       <= 1'b0;
      swapped    <= 1'b0;
      digit0     <= 3'd0;
      digit1     <= 3'd0;
      blank1     <= 1'b0;
      swap_pulse <= 1'b0;
      holding    <= 1'b0;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_prev  <= 1'b1;
    end else begin
      sync1      <= hold_n;
      sync2      <= sync1;
      sync_prev  <= sync2;
      swap_pulse <= 1'b0;

      case (state)
        S_RUN: begin
          digit0 <= swapped ? cnt_b : cnt_a;
          digit1 <= swapped ? cnt_a : cnt_b;
          if (pcnt == P_LAST) begin
            pcnt   <= '0;
            state  <= S_BLANK;
            blank1 <= 1'b1;
            // A press colliding with the terminal count waits for the swap.
            if (press) pend <= 1'b1;
          end else begin
            pcnt <= pcnt + 1'b1;
            if (press) begin
              state   <= S_HOLD;
              holding <= 1'b1;
            end
          end
        end

        S_BLANK: begin
          digit0 <= swapped ? cnt_b : cnt_a;
          digit1 <= swapped ? cnt_a : cnt_b;
          if (bcnt == B_LAST) begin
            bcnt       <= '0;
            swapped    <= ~swapped;
            swap_pulse <= 1'b1;
            blank1     <= 1'b0;
            pend       <= 1'b0;
            // A press on the final blank tick is honoured like a deferred one.
            if (pend || press) begin
              state   <= S_HOLD;
              holding <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
            if (press) pend <= 1'b1;
          end
        end

        S_HOLD: begin
          if (press) begin
            state   <= S_RUN;
            holding <= 1'b0;
          end
        end

        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule
